// File: rtl/impulse_capture.sv
// Impulse-response capture controller: arms on start, waits for an onset above
// threshold, then streams IMPULSE_LENGTH samples into the impulse memory from address 0.
module impulse_capture #(
  parameter int IMPULSE_LENGTH  = 48000,
  parameter int ADDR_WIDTH      = 16,
  parameter int TIMEOUT_SAMPLES = 96000
) (
  input  logic                  audio_clk,
  input  logic                  rst_in_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           sample_in,
  input  logic                  sample_valid,
  input  logic [15:0]           threshold,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [15:0]           write_data,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           peak_abs,
  output logic                  clipped
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_ARMED   | waiting for onset; wait timer running
  // S_CAPTURE | writing one sample per valid input
  // S_DONE    | capture complete; waiting for next start
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int WAIT_W = (TIMEOUT_SAMPLES > 1) ? $clog2(TIMEOUT_SAMPLES) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(TIMEOUT_SAMPLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMPULSE_LENGTH - 1);

  state_t                state, state_nxt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [16:0]           mag_wide;
  logic [15:0]           mag;
  logic                  arm, accept, wait_dec, done_nxt, timeout_nxt;

  // |sample| in 17 bits so -32768 is representable, then clamp to 32767
  always_comb begin
    mag_wide = sample_in[15] ? (17'd0 - {1'b1, sample_in}) : {1'b0, sample_in};
    mag      = (mag_wide > 17'd32767) ? 16'h7fff : mag_wide[15:0];
  end

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    arm         = 1'b0;
    accept      = 1'b0;
    wait_dec    = 1'b0;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nxt = S_ARMED;
            arm       = 1'b1;
          end
        end
        S_ARMED: begin
          if (sample_valid) begin
            if (mag >= threshold) begin
              accept = 1'b1;
              if (addr_cnt == LAST_ADDR) begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = S_CAPTURE;
              end
            end else if (wait_cnt == '0) begin
              state_nxt   = S_IDLE;
              timeout_nxt = 1'b1;
            end else begin
              wait_dec = 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            accept = 1'b1;
            if (addr_cnt == LAST_ADDR) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wait_cnt     <= '0;
      addr_cnt     <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      peak_abs     <= '0;
      clipped      <= 1'b0;
    end else begin
      write_enable <= accept;
      done         <= done_nxt;
      timeout      <= timeout_nxt;
      busy         <= (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
      if (arm) begin
        wait_cnt <= WAIT_LOAD;
        addr_cnt <= '0;
        peak_abs <= '0;
        clipped  <= 1'b0;
      end else if (wait_dec) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (accept) begin
        write_addr <= addr_cnt;
        write_data <= sample_in;
        addr_cnt   <= addr_cnt + ADDR_WIDTH'(1);
        if (mag > peak_abs) peak_abs <= mag;
        if ((sample_in == 16'h7fff) || (sample_in == 16'h8000)) clipped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_impulse_capture.sv
// Directed bench for impulse_capture with a short capture length and timeout.
module tb_impulse_capture;

  logic        audio_clk = 1'b0;
  logic        rst_in_n  = 1'b0;
  logic        start = 1'b0, abort = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_in = '0, threshold = 16'd1000;
  logic [15:0] write_addr, write_data, peak_abs;
  logic        write_enable, busy, done, timeout, clipped;

  int n_total = 0, n_pass = 0;
  int done_seen = 0, to_seen = 0;
  logic [15:0] wa_q[$], wd_q[$];
  logic        wdone_q[$];

  impulse_capture #(.IMPULSE_LENGTH(8), .ADDR_WIDTH(16), .TIMEOUT_SAMPLES(4)) dut (
    .audio_clk(audio_clk), .rst_in_n(rst_in_n), .start(start), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid), .threshold(threshold),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .busy(busy), .done(done), .timeout(timeout), .peak_abs(peak_abs), .clipped(clipped)
  );

  always #5 audio_clk = ~audio_clk;

  always @(negedge audio_clk) begin
    if (write_enable) begin
      wa_q.push_back(write_addr);
      wd_q.push_back(write_data);
      wdone_q.push_back(done);
    end
    if (done) done_seen++;
    if (timeout) to_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input logic st, input logic ab, input logic v, input logic [15:0] s);
    @(negedge audio_clk);
    start = st; abort = ab; sample_valid = v; sample_in = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  logic [15:0] exp_basic[8] = '{16'd1500, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
  logic [15:0] exp_gap[8]   = '{16'd1200, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17};
  int base, d0, t0;

  initial begin
    #12;
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", write_addr, 0);
    check("rst_data", write_data, 0);
    check("rst_done_to", {done, timeout, clipped}, 0);
    check("rst_peak", peak_abs, 0);
    @(negedge audio_clk);
    rst_in_n = 1'b1;

    // basic capture: 10 and -20 stay below threshold, 1500 triggers
    base = wa_q.size(); d0 = done_seen;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'd10);
    check("busy_rise", busy, 1);
    cyc(0, 0, 1, -16'sd20);
    cyc(0, 0, 1, 16'd1500);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 16'd5);
    idle(3);
    check("basic_nwr", wa_q.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("basic_addr%0d", i), wa_q[base+i], i);
      check($sformatf("basic_data%0d", i), wd_q[base+i], exp_basic[i]);
    end
    check("basic_done_last", wdone_q[base+7], 1);
    check("basic_done_early", wdone_q[base+6], 0);
    check("basic_done_cnt", done_seen - d0, 1);
    check("basic_peak", peak_abs, 1500);
    check("basic_clip", clipped, 0);
    check("basic_busy", busy, 0);

    // timeout after four sub-threshold samples
    base = wa_q.size(); t0 = to_seen;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 16'd999);
    check("to_busy_before", busy, 1);
    check("to_early", timeout, 0);
    idle(1);
    check("to_pulse", timeout, 1);
    check("to_busy", busy, 0);
    idle(1);
    check("to_one_cycle", timeout, 0);
    check("to_cnt", to_seen - t0, 1);
    check("to_nwr", wa_q.size() - base, 0);

    // saturation on the triggering sample
    base = wa_q.size(); d0 = done_seen;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'h8000);
    idle(1);
    check("sat_we", write_enable, 1);
    check("sat_addr", write_addr, 0);
    check("sat_data", write_data, 16'h8000);
    check("sat_peak", peak_abs, 16'h7fff);
    check("sat_clip", clipped, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 16'd0);
    idle(2);
    check("sat_done_cnt", done_seen - d0, 1);
    check("sat_clip_hold", clipped, 1);

    // abort coincident with the address-3 sample
    base = wa_q.size(); d0 = done_seen;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'd2000);
    check("abort_clip_clr", clipped, 0);
    cyc(0, 0, 1, 16'd100);
    cyc(0, 0, 1, 16'd200);
    cyc(0, 1, 1, 16'd300);
    idle(3);
    check("abort_nwr", wa_q.size() - base, 3);
    check("abort_last_addr", wa_q[wa_q.size()-1], 2);
    check("abort_no_done", done_seen - d0, 0);
    check("abort_busy", busy, 0);
    check("abort_peak_hold", peak_abs, 2000);

    // restart: back-to-back, ignored start, then every third cycle
    base = wa_q.size(); d0 = done_seen;
    cyc(1, 0, 0, 0);
    idle(1);
    check("restart_peak_clr", peak_abs, 0);
    check("restart_busy", busy, 1);
    cyc(0, 0, 1, 16'd1200);
    cyc(0, 0, 1, 16'd11);
    cyc(1, 0, 1, 16'd12);
    cyc(0, 0, 1, 16'd13);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 16'(14 + i));
      idle(2);
    end
    idle(1);
    check("gap_nwr", wa_q.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("gap_addr%0d", i), wa_q[base+i], i);
      check($sformatf("gap_data%0d", i), wd_q[base+i], exp_gap[i]);
    end
    check("gap_done_cnt", done_seen - d0, 1);
    check("gap_done_last", wdone_q[base+7], 1);
    check("gap_peak", peak_abs, 1200);

    // threshold 0 triggers on a zero sample; async reset mid-capture
    threshold = 16'd0;
    base = wa_q.size();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 16'd0);
    cyc(0, 0, 1, -16'sd3);
    @(posedge audio_clk);
    #2;
    check("pre_rst_we", write_enable, 1);
    check("pre_rst_addr", write_addr, 1);
    rst_in_n = 1'b0;
    #1;
    check("arst_we", write_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", write_addr, 0);
    check("arst_data", write_data, 0);
    check("arst_peak", peak_abs, 0);
    check("thr0_first_data", wd_q[base], 0);
    check("thr0_first_addr", wa_q[base], 0);
    @(negedge audio_clk);
    rst_in_n = 1'b1; sample_valid = 1'b0; start = 1'b0;
    base = wa_q.size();
    cyc(0, 0, 1, 16'd500);
    idle(2);
    check("post_rst_idle_nwr", wa_q.size() - base, 0);
    check("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/impulse_capture.md
# impulse_capture

Capture controller that records a room impulse response into the impulse memory. It sits directly upstream of the impulse memory manager and drives its write port. When armed, it waits for the incoming audio stream to cross an onset threshold, then writes exactly `IMPULSE_LENGTH` consecutive samples starting at address 0. It reports completion, timeout, peak magnitude and clipping to the control logic.

## Interface
- `IMPULSE_LENGTH`, 48000: number of samples captured; must be ≤ 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 16: width of `write_addr`.
- `TIMEOUT_SAMPLES`, 96000: valid samples to wait in ARMED before giving up; ≥ 1.
- `audio_clk` in 1: sole clock, rising edge.
- `rst_in_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle arm request.
- `abort` in 1: one-cycle cancel request.
- `sample_in` in 16 (signed): audio sample.
- `sample_valid` in 1: `sample_in` valid this cycle; may be high on consecutive cycles.
- `threshold` in 16 (unsigned): onset magnitude; sampled continuously.
- `write_addr` out `ADDR_WIDTH`: memory write address.
- `write_data` out 16 (signed): memory write data.
- `write_enable` out 1: one-cycle write strobe.
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: one-cycle pulse on capture completion.
- `timeout` out 1: one-cycle pulse on onset timeout.
- `peak_abs` out 16: largest |sample| written in the current/last capture.
- `clipped` out 1: a captured sample equalled 32767 or -32768.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- **IDLE/DONE + `start`:**
  - Go to ARMED.
  - Clear `peak_abs`, `clipped`, the wait counter and the address counter.
- **`start` in ARMED/CAPTURE:** ignored.
- **Magnitude:** mag = |sample_in|, computed in 17 bits. -32768 saturates to 32767.
- **ARMED, on `sample_valid`:**
  - If mag ≥ `threshold`, go to CAPTURE. This sample is the first captured sample (address 0).
  - Otherwise, increment the wait counter. When the counter reaches `TIMEOUT_SAMPLES`, go to IDLE and pulse `timeout`.
- **`threshold` = 0:** the first valid sample in ARMED triggers.
- **CAPTURE:**
  - Every valid sample is written at the current address, then the address increments.
  - The write of address `IMPULSE_LENGTH`-1 moves the state to DONE.
  - Samples arriving in DONE/IDLE are ignored.
- **Per captured sample:**
  - `peak_abs` = max(`peak_abs`, mag).
  - `clipped` is set if the raw sample is 32767 or -32768 (sticky until next `start`).
- **`abort`:** from any state go to IDLE next cycle. No `done` or `timeout` pulse. `abort` has priority over `start` and `sample_valid` in the same cycle; no write is issued for that sample.
- **`done`/`timeout` in the same cycle:** impossible by construction.
- **Reset mid-capture:**
  - All state clears immediately.
  - Memory contents already written are left as-is.
  - `write_enable` drops asynchronously.

## Timing
- **Reset values:** state IDLE. `write_addr`=0, `write_data`=0, `write_enable`=0, `busy`=0, `done`=0, `timeout`=0, `peak_abs`=0, `clipped`=0.
- **Registered outputs:** all outputs are registered.
- **Write latency:** one cycle.
  - A sample accepted on cycle N produces `write_enable`=1 on cycle N+1, with `write_addr`/`write_data` valid that cycle.
  - `write_enable` is high for exactly one cycle per captured sample.
  - `write_addr`/`write_data` hold their last values otherwise.
- **Triggering sample:** written on the cycle after it arrives, at address 0.
- **`done`:** asserted in the same cycle as the final `write_enable` (address `IMPULSE_LENGTH`-1). `busy` falls in that same cycle.
- **`timeout`:** asserted the cycle after the `TIMEOUT_SAMPLES`-th non-triggering valid sample. `busy` falls in that same cycle.
- **`busy` rise:** the cycle after `start` is accepted.
- **Throughput:** one sample per cycle sustained; no backpressure.
- **`peak_abs`/`clipped`:** updated in the same cycle as the corresponding `write_enable`.

## Test plan
- **Basic capture:** `IMPULSE_LENGTH`=8, `threshold`=1000. Sequence: `start`, samples 10, -20, 1500, then 7 more of value 5.
  - Writes at addresses 0..7 with data 1500, 5, 5, 5, 5, 5, 5, 5.
  - `done` pulses with the address-7 write.
  - `peak_abs`=1500, `clipped`=0.
- **Timeout:** `TIMEOUT_SAMPLES`=4, `threshold`=1000, four samples of 999.
  - No writes.
  - `timeout` pulses the cycle after the 4th sample; `busy`=0.
- **Saturation:** trigger with -32768.
  - `write_data`=-32768, `peak_abs`=32767, `clipped`=1.
- **Abort mid-capture:** `abort` coincident with a valid sample at address 3.
  - No write for that sample; no `done`.
  - Next `start` restarts at address 0 with `peak_abs` cleared.
- **Back-to-back samples and idle gaps:** `sample_valid` high every cycle, then every 3rd cycle.
  - Addresses contiguous, one write per sample.
  - `start` during CAPTURE is ignored.
- **Async reset:** assert `rst_in_n`=0 mid-capture without a clock edge.
  - All outputs 0 immediately; state IDLE after release.
